addsub_stage_ctrl: RTL and testbench

- Sequencing stage wrapped around the 32-bit carry-lookahead adder. It sits directly upstream and downstream of that adder.
- Accepts operand/opcode packets over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the adder inputs (with operand inversion and carry-in selection for subtract and carry-chained ops).
- Registers the adder's sum/cout plus status flags into a single output stage with its own valid/ready handshake.
- Maintains a sticky carry flag so multi-word (64/96/128-bit) add and subtract can be chained across packets.

---
 rtl/addsub_stage_ctrl_if.sv | 46 ++++
 rtl/addsub_stage_ctrl.sv | 149 ++++++++++++++
 tb/tb_addsub_stage_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// addsub_stage_ctrl_if
//   Packet-side bus of the add/sub sequencing stage: the input packet channel
//   and the registered result channel.
//
//   Handshake semantics (both channels): a transfer happens at a rising clock
//   edge where valid && ready are both 1. The producer keeps valid and payload
//   stable until the transfer; ready never depends combinationally on valid.
//
//   Signals:
//     in_valid / in_ready   input packet handshake
//     in_a, in_b            operands (WIDTH bits)
//     in_op                 2'b00 ADD, 2'b01 SUB, 2'b10 ADC, 2'b11 SBC
//     out_valid / out_ready result handshake
//     out_sum               registered result (WIDTH bits)
//     out_c, out_v          carry (not-borrow for SUB/SBC), signed overflow
//     out_z, out_n          zero, negative of out_sum
//
//   Modports: slave = the stage itself, master = packet source/result sink.
// -----------------------------------------------------------------------------
interface addsub_stage_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_c;
  logic             out_v;
  logic             out_z;
  logic             out_n;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
  );
endinterface

// File: rtl/addsub_stage_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_stage_ctrl
//   Sequencing stage wrapped around an external WIDTH-bit adder. Packets are
//   buffered in a DEPTH-entry circular FIFO; the FIFO head is always presented
//   to the adder (B inverted and carry-in selected per opcode). On issue the
//   adder result plus C/V/Z/N flags are captured into a single output register
//   stage with its own valid/ready handshake. A sticky carry flag, updated on
//   every issue, lets ADC/SBC chain multi-word arithmetic across packets.
//
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     bus (slave modport)    input packet channel and result channel
//     add_a, add_b, add_cin  operands to the adder
//     add_sum, add_cout      combinational adder return
//
//   Build option: define ADDSUB_SAT_EN to clamp overflowing results to the
//   most positive / most negative signed value. Without it results wrap.
// -----------------------------------------------------------------------------
module addsub_stage_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_stage_ctrl_if.slave bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam int          MSB     = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [1:0]       r_mem_op [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Output stage and sticky carry
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_c;
  logic             r_out_v;
  logic             r_out_z;
  logic             r_out_n;
  logic             r_carry;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_issue;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [1:0]       w_head_op;
  logic             w_v;
  logic [WIDTH-1:0] w_res;

  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = bus.in_valid && !w_full;
  // Output stage is free when empty or being drained this same edge.
  assign w_issue = !w_empty && (!r_out_valid || bus.out_ready);

  assign w_head_a  = r_mem_a[r_rptr[AW-1:0]];
  assign w_head_b  = r_mem_b[r_rptr[AW-1:0]];
  assign w_head_op = r_mem_op[r_rptr[AW-1:0]];

  // op[0] marks subtraction: a - b is computed as a + ~b + cin.
  always_comb begin
    add_a   = w_head_a;
    add_b   = w_head_op[0] ? ~w_head_b : w_head_b;
    add_cin = r_carry;
    if (w_head_op == OP_ADD) add_cin = 1'b0;
    if (w_head_op == OP_SUB) add_cin = 1'b1;
  end

  // Overflow: operands agree in sign, result sign differs.
  assign w_v = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);

`ifdef ADDSUB_SAT_EN
  always_comb begin
    w_res = add_sum;
    if (w_v) w_res = add_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_res = add_sum;
`endif

  // FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i]  <= '0;
        r_mem_b[i]  <= '0;
        r_mem_op[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_a[r_wptr[AW-1:0]]  <= bus.in_a;
        r_mem_b[r_wptr[AW-1:0]]  <= bus.in_b;
        r_mem_op[r_wptr[AW-1:0]] <= bus.in_op;
        r_wptr                   <= r_wptr + PTR_ONE;
      end
      if (w_issue) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Output stage and carry flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_c     <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_z     <= 1'b0;
      r_out_n     <= 1'b0;
      r_carry     <= 1'b0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_res;
      r_out_c     <= add_cout;
      r_out_v     <= w_v;
      r_out_z     <= (w_res == '0);
      r_out_n     <= w_res[MSB];
      r_carry     <= add_cout;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_c     = r_out_c;
  assign bus.out_v     = r_out_v;
  assign bus.out_z     = r_out_z;
  assign bus.out_n     = r_out_n;

endmodule

// File: tb/tb_addsub_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addsub_stage_ctrl
//   Bench for addsub_stage_ctrl (WIDTH=32, DEPTH=2) with a behavioural adder.
//   Expected results come from an arithmetic reference model applied in
//   acceptance order; results are packed {sum, c, v, z, n} in exp_q.
// -----------------------------------------------------------------------------
module tb_addsub_stage_ctrl;
  localparam int W  = 32;
  localparam int RW = W + 4;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ADC = 2'b10;
  localparam logic [1:0] SBC = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_stage_ctrl_if #(.WIDTH(W)) bus ();

  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  // Attached carry-lookahead adder, modelled behaviourally.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  addsub_stage_ctrl #(.WIDTH(W), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic          m_carry = 1'b0;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_pop   = 0;
  logic [RW-1:0] last_out = '0;
  logic [RW-1:0] prev_obs = '0;
  logic          hold_prev = 1'b0;
  logic          accepted = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    longint  sa, sb, sr, ua, ub, ur;
    logic    cin;
    logic [W-1:0] s;
    logic    c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    cin = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : m_carry;
    if (op[0] == 1'b0) begin
      ur = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      c  = (ur >= 64'sh1_0000_0000);
    end else begin
      // borrow = !cin; carry out means no borrow
      ur = ua - ub - longint'(!cin);
      sr = sa - sb - longint'(!cin);
      c  = (ur >= 0);
    end
    s = ur[W-1:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
    if (v) s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    m_carry = c;
    exp_q.push_back({s, c, v, (s == '0), s[W-1]});
  endtask

  function automatic logic [RW-1:0] obs_pack();
    return {bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n};
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after rising.
  task automatic cycle();
    logic [RW-1:0] obs;
    @(negedge clk);
    obs = obs_pack();
    if (hold_prev) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", 64'(obs), 64'(prev_obs));
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_obs  = obs;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        check("result", 64'(obs), 64'(exp_q.pop_front()));
        last_out = obs;
        n_pop++;
      end
    end
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) model_push(bus.in_a, bus.in_b, bus.in_op);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push1(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    accepted     = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) cycle();
    check("push_timeout", 64'(accepted), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic busy;
    busy = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      cycle();
      busy = (exp_q.size() != 0) || bus.out_valid;
    end
    check("drain_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [RW-1:0] held;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = ADD;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_fields", 64'(obs_pack()), 64'd0);
    rst_n = 1'b1;
    cycle();

    // ADD 5+3 with one-cycle latency
    bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_a = 32'd5; bus.in_b = 32'd3;
    cycle();
    bus.in_valid = 1'b0;
    check("lat_edge_e", 64'(bus.out_valid), 64'd0);
    cycle();
    check("lat_edge_e1", 64'(bus.out_valid), 64'd1);
    drain();
    check("add_5_3", 64'(last_out), 64'({32'd8, 4'b0000}));

    push1(SUB, 32'd3, 32'd5); drain();
    check("sub_3_5", 64'(last_out), 64'({32'hFFFF_FFFE, 4'b0001}));
    push1(SUB, 32'd7, 32'd7); drain();
    check("sub_7_7", 64'(last_out), 64'({32'd0, 4'b1010}));

    // 64-bit chain
    push1(ADD, 32'hFFFF_FFFF, 32'd1); drain();
    check("chain_lo", 64'(last_out), 64'({32'd0, 4'b1010}));
    push1(ADC, 32'd0, 32'd0); drain();
    check("chain_hi", 64'(last_out), 64'({32'd1, 4'b0000}));

    // signed overflow
    push1(ADD, 32'h7FFF_FFFF, 32'd1); drain();
`ifdef ADDSUB_SAT_EN
    check("ovf_sat", 64'(last_out), 64'({32'h7FFF_FFFF, 4'b0100}));
`else
    check("ovf_wrap", 64'(last_out), 64'({32'h8000_0000, 4'b0101}));
`endif

    // backpressure: 3 packets with the consumer stalled
    bus.out_ready = 1'b0;
    n_pop = 0;
    push1(ADD, 32'd10, 32'd20);
    push1(SUB, 32'd100, 32'd1);
    push1(ADD, 32'd1, 32'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    held = obs_pack();
    bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_a = 32'd9; bus.in_b = 32'd9;
    repeat (3) cycle();
    bus.in_valid = 1'b0;
    check("bp_full_hold", 64'(bus.in_ready), 64'd0);
    check("bp_first_held", 64'(obs_pack()), 64'(held));
    bus.out_ready = 1'b1;
    drain();
    check("bp_delivered", 64'(n_pop), 64'd3);

    // reset with FIFO full and a result held; held result leaves carry=1
    bus.out_ready = 1'b0;
    push1(ADD, 32'hFFFF_FFFF, 32'd1);
    push1(ADD, 32'd1, 32'd1);
    push1(ADD, 32'd2, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    m_carry   = 1'b0;
    hold_prev = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    push1(ADC, 32'd0, 32'd0); drain();
    check("adc_after_rst", 64'(last_out), 64'({32'd0, 4'b0010}));

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || accepted) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_op    = 2'($urandom_range(0, 3));
        bus.in_a     = rand_word();
        bus.in_b     = rand_word();
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
